// File: rtl/atm_timer_pkg.sv
// Shared types and defaults for the ATM timer bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package atm_timer_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 32;
  localparam int unsigned DEF_PRE_W  = 8;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_EXPIRED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timeout channel: counts shared ticks up to a threshold; one-shot or periodic.
// Latency: expire_pulse_o/time_out_o register on the edge that sees tick with count >= threshold.
// Backpressure: none; the channel free-runs on tick and never stalls.
// Ports: clk_i/rst_i (async active-high); tick_i shared prescaler tick; enable_i, restart_i,
//        periodic_i, threshold_i, clear_i control; time_out_o sticky flag, time_out_nxt_o its
//        next state (for the bank-level OR), expire_pulse_o one-cycle expiry pulse.
module timer_channel
  import atm_timer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic             periodic_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic             clear_i,
  output logic             time_out_o,
  output logic             time_out_nxt_o,
  output logic             expire_pulse_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             time_out_q, time_out_d;
  logic             pulse_q, pulse_d;
  logic             expire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    unique case (state_q)
      T_IDLE: begin
        cnt_d = '0;
        if (enable_i) state_d = T_RUN;
      end
      T_RUN: begin
        if (!enable_i) begin
          state_d = T_IDLE;
          cnt_d   = '0;
        end else if (restart_i) begin
          // Restart outranks a coincident expiry.
          cnt_d = '0;
        end else if (tick_i) begin
          // >= so a threshold lowered below the count fires on the next tick; the
          // counter stops at threshold, so it cannot wrap.
          if (cnt_q >= threshold_i) begin
            expire = 1'b1;
            if (periodic_i) cnt_d = '0;
            else            state_d = T_EXPIRED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      T_EXPIRED: begin
        if (!enable_i) begin
          state_d = T_IDLE;
          cnt_d   = '0;
        end else if (restart_i) begin
          state_d = T_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = T_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Set wins over clear when both land in the same cycle.
    time_out_d = expire | (time_out_q & ~clear_i);
    pulse_d    = expire;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= T_IDLE;
      cnt_q      <= '0;
      time_out_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      time_out_q <= time_out_d;
      pulse_q    <= pulse_d;
    end
  end

  assign time_out_o     = time_out_q;
  assign time_out_nxt_o = time_out_d;
  assign expire_pulse_o = pulse_q;

endmodule

// File: rtl/atm_timer_bank.sv
// Bank of NUM_CH timeout channels sharing one prescaler tick (every prescale+1 cycles).
// Latency: with prescale=0 and threshold T, expiry registers T+1 edges after enable is sampled.
// Backpressure: none; all outputs are level/pulse status, no handshake.
// Ports: clk, rst (async active-high); prescale tick divider; enable/restart/periodic/clear
//        per-channel controls; threshold packed per channel ([i*CNT_W +: CNT_W]);
//        time_out sticky flags, expire_pulse one-cycle pulses, any_time_out registered OR.
module atm_timer_bank
  import atm_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned PRE_W  = DEF_PRE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRE_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] threshold,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       time_out,
  output logic [NUM_CH-1:0]       expire_pulse,
  output logic                    any_time_out
);

  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick;
  logic              any_en;
  logic              any_time_out_q, any_time_out_d;
  logic [NUM_CH-1:0] time_out_nxt;

  // Prescaler idles at 0 when no channel runs. >= (not ==) means lowering
  // prescale below the current count ticks immediately instead of wrapping.
  always_comb begin
    any_en    = |enable;
    tick      = any_en && (pre_cnt_q >= prescale);
    pre_cnt_d = (!any_en || tick) ? '0 : pre_cnt_q + PRE_ONE;
  end

  // OR of next-state flags so any_time_out moves on the same edge as time_out.
  assign any_time_out_d = |time_out_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      any_time_out_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      any_time_out_q <= any_time_out_d;
    end
  end

  assign any_time_out = any_time_out_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i          (clk),
      .rst_i          (rst),
      .tick_i         (tick),
      .enable_i       (enable[i]),
      .restart_i      (restart[i]),
      .periodic_i     (periodic[i]),
      .threshold_i    (threshold[i*CNT_W +: CNT_W]),
      .clear_i        (clear[i]),
      .time_out_o     (time_out[i]),
      .time_out_nxt_o (time_out_nxt[i]),
      .expire_pulse_o (expire_pulse[i])
    );
  end

endmodule

// File: tb/tb_atm_timer_bank.sv
// Self-checking bench for atm_timer_bank: expected expiry pulses (channel, edge) are queued
// when stimulus is applied and popped by a monitor whenever the DUT pulses.
// Flag/OR state is checked directly at chosen points.
module tb_atm_timer_bank;

  localparam int NC = 4;
  localparam int CW = 32;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PW-1:0]    prescale;
  logic [NC-1:0]    enable, restart, periodic, clear;
  logic [NC*CW-1:0] threshold;
  logic [NC-1:0]    time_out, expire_pulse;
  logic             any_time_out;

  atm_timer_bank #(.NUM_CH(NC), .CNT_W(CW), .PRE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .prescale     (prescale),
    .enable       (enable),
    .restart      (restart),
    .periodic     (periodic),
    .threshold    (threshold),
    .clear        (clear),
    .time_out     (time_out),
    .expire_pulse (expire_pulse),
    .any_time_out (any_time_out)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
  endtask

  task automatic expect_pulse(input int ch, input int at);
    ev_t e;
    e.ch  = ch;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic end_phase(input string tag);
    chk({tag, "_missed_pulses"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_thr(input int ch, input logic [CW-1:0] v);
    threshold[ch*CW +: CW] = v;
  endtask

  // Pulse monitor: each pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NC; ch++) begin
        if (expire_pulse[ch]) begin
          chk("pulse_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("pulse_ch", ch, mon_e.ch);
            chk("pulse_edge", cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int c2;
    prescale  = 8'd0;
    enable    = 4'hF;
    restart   = '0;
    periodic  = '0;
    clear     = '0;
    threshold = '0;

    // Reset held with all channels enabled.
    repeat (3) @(negedge clk);
    chk("rst_time_out", time_out, 0);
    chk("rst_pulse", expire_pulse, 0);
    chk("rst_any", any_time_out, 0);
    chk("rst_pre_cnt", dut.pre_cnt_q, 0);
    enable = '0;
    rst    = 1'b0;

    // One-shot, threshold 3, prescale 0: pulse after edge T+1 from enable.
    @(negedge clk);
    set_thr(0, 32'd3);
    c = cyc;
    enable = 4'b0001;
    expect_pulse(0, c + 5);
    goto(c + 5);
    chk("oneshot_to_set", time_out[0], 1'b1);
    chk("oneshot_any_set", any_time_out, 1'b1);
    goto(c + 10);
    chk("oneshot_to_sticky", time_out[0], 1'b1);
    end_phase("oneshot");
    enable = '0;
    clear  = 4'b0001;
    @(negedge clk);
    clear = '0;
    chk("oneshot_cleared", time_out, 0);
    chk("oneshot_any_cleared", any_time_out, 1'b0);

    // Periodic, threshold 2: pulse every 3 cycles, 10 expiries.
    c = cyc;
    periodic = 4'b0010;
    set_thr(1, 32'd2);
    enable = 4'b0010;
    for (int k = 0; k < 10; k++) expect_pulse(1, c + 4 + 3 * k);
    goto(c + 4);
    clear = 4'b0010;
    goto(c + 5);
    clear = '0;
    chk("periodic_clear", time_out[1], 1'b0);
    chk("periodic_any_clear", any_time_out, 1'b0);
    goto(c + 6);
    clear = 4'b0010;
    goto(c + 7);
    clear = '0;
    chk("periodic_set_wins", time_out[1], 1'b1);
    chk("periodic_any_set_wins", any_time_out, 1'b1);
    goto(c + 32);
    enable   = '0;
    periodic = '0;
    clear    = 4'b0010;
    goto(c + 33);
    clear = '0;
    goto(c + 36);
    end_phase("periodic");
    chk("periodic_off_to", time_out, 0);

    // Prescaler 4 (tick every 5 cycles), threshold 1: expiry 10 edges after enable.
    prescale = 8'd4;
    set_thr(2, 32'd1);
    c = cyc;
    enable = 4'b0100;
    expect_pulse(2, c + 10);
    goto(c + 10);
    chk("pre_to_set", time_out[2], 1'b1);
    restart = 4'b0100;
    set_thr(2, 32'd0);
    goto(c + 11);
    restart = '0;
    goto(c + 13);
    chk("pre_cnt_at_3", dut.pre_cnt_q, 3);
    // Lowering prescale below pre_cnt: tick on the very next edge.
    prescale = 8'd1;
    expect_pulse(2, c + 14);
    goto(c + 17);
    end_phase("prescale");
    enable   = '0;
    clear    = 4'b0100;
    prescale = 8'd0;
    @(negedge clk);
    clear = '0;

    // Restart at count 4 delays expiry to 6 ticks later; restart coinciding
    // with a would-be expiry suppresses it.
    set_thr(3, 32'd5);
    c = cyc;
    enable = 4'b1000;
    goto(c + 5);
    restart = 4'b1000;
    goto(c + 6);
    restart = '0;
    expect_pulse(3, c + 12);
    goto(c + 13);
    restart = 4'b1000;
    clear   = 4'b1000;
    goto(c + 14);
    restart = '0;
    clear   = '0;
    chk("restart_to_cleared", time_out[3], 1'b0);
    goto(c + 19);
    restart = 4'b1000;
    goto(c + 20);
    restart = '0;
    chk("restart_beats_expiry", time_out[3], 1'b0);
    expect_pulse(3, c + 26);
    goto(c + 28);
    end_phase("restart");
    enable = '0;
    clear  = 4'b1000;
    @(negedge clk);
    clear = '0;

    // Enable drop mid-count: to IDLE, flag kept, no pulse; re-enable restarts full latency.
    set_thr(0, 32'd3);
    c = cyc;
    enable = 4'b0001;
    expect_pulse(0, c + 5);
    goto(c + 6);
    restart = 4'b0001;
    goto(c + 7);
    restart = '0;
    goto(c + 9);
    enable = '0;
    goto(c + 12);
    chk("drop_keeps_to", time_out[0], 1'b1);
    chk("drop_keeps_any", any_time_out, 1'b1);
    c2 = cyc;
    enable = 4'b0001;
    expect_pulse(0, c2 + 5);
    goto(c2 + 7);
    end_phase("drop");

    // Asynchronous reset mid-count takes effect without a clock edge.
    restart = 4'b0001;
    @(negedge clk);
    restart = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_to", time_out, 0);
    chk("arst_any", any_time_out, 1'b0);
    chk("arst_pulse", expire_pulse, 0);
    enable = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    end_phase("arst");

    // Threshold lowered mid-run, concurrent multi-channel expiries and OR.
    set_thr(0, 32'd100);
    set_thr(1, 32'd100);
    set_thr(2, 32'd51);
    c = cyc;
    enable = 4'b0111;
    goto(c + 51);
    set_thr(0, 32'd10);
    set_thr(1, 32'd10);
    expect_pulse(0, c + 52);
    expect_pulse(1, c + 52);
    expect_pulse(2, c + 53);
    goto(c + 52);
    chk("multi_to_a", time_out, 4'b0011);
    chk("multi_any_a", any_time_out, 1'b1);
    goto(c + 53);
    chk("multi_to_b", time_out, 4'b0111);
    enable = '0;
    clear  = 4'b0011;
    goto(c + 54);
    clear = 4'b0100;
    chk("multi_to_c", time_out, 4'b0100);
    chk("multi_any_c", any_time_out, 1'b1);
    goto(c + 55);
    clear = '0;
    chk("multi_to_d", time_out, 0);
    chk("multi_any_d", any_time_out, 1'b0);
    goto(c + 58);
    end_phase("multi");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
